lb_modport_slave: RTL and testbench

Local-bus slave register file that answers host read/write transactions on the synesthesia internal local bus (rd_en/wr_en/addr/wr_data in; wr_valid/rd_valid/rd_data out). It holds a bank of control registers that the rest of the design uses, plus an ID register and a status register. It sits behind the host bridge and is the target exercised by the local-bus TB agent.

---
 rtl/syn_lb_pkg.sv | 14 +
 rtl/lb_addr_decode.sv | 18 +
 rtl/lb_modport_slave.sv | 75 +++++++
 tb/tb_lb_modport_slave.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/syn_lb_pkg.sv
// Shared local-bus constants: register map, ID word and the filler returned
// for reads that miss the map.
package syn_lb_pkg;
  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  localparam int unsigned ID_ADDR      = 0;
  localparam int unsigned STS_ADDR     = 1;
  localparam int unsigned SCRATCH_ADDR = 2;
  localparam int unsigned CTRL_BASE    = 3;

  localparam word_t LB_ID_VAL   = 32'h5359_4E01;
  localparam word_t LB_ERR_DATA = 32'hDEAD_DEAD;
endpackage

// File: rtl/lb_addr_decode.sv
// Combinational local-bus address decode: in-map hit, read-only flag and slot index.
module lb_addr_decode
  import syn_lb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic              ro,
  output logic [IDX_W-1:0]  idx
);
  assign hit = (addr < ADDR_W'(NUM_REGS));
  assign ro  = hit && ((addr == ADDR_W'(ID_ADDR)) || (addr == ADDR_W'(STS_ADDR)));
  // Only meaningful when hit is set; upper bits are covered by the range check.
  assign idx = addr[IDX_W-1:0];
endmodule

// File: rtl/lb_modport_slave.sv
// Local-bus slave register file: ID and live status (RO), scratch and control
// registers (RW), with a fixed one-cycle ack for every read and write strobe.
module lb_modport_slave
  import syn_lb_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VAL   = LB_ID_VAL,
  parameter logic [DATA_W-1:0] ERR_DATA = LB_ERR_DATA
) (
  input  logic                       clk_ir,
  input  logic                       rst_il,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          sts_i,
  output logic                       wr_valid,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic                             hit, ro;
  logic [IDX_W-1:0]                 idx;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q;
  logic [DATA_W-1:0]                rd_mux;

  lb_addr_decode #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec (
    .addr (addr),
    .hit  (hit),
    .ro   (ro),
    .idx  (idx)
  );

  // RO slots are never written, so regs_q[0..1] stay at their reset value.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il)                 regs_q      <= '0;
    else if (wr_en && hit && !ro) regs_q[idx] <= wr_data;
  end

  // Mux reads the pre-edge register value, giving read-before-write on collision.
  always_comb begin
    rd_mux = ERR_DATA;
    if (hit) begin
      if (idx == IDX_W'(ID_ADDR))       rd_mux = ID_VAL;
      else if (idx == IDX_W'(STS_ADDR)) rd_mux = sts_i;
      else                              rd_mux = regs_q[idx];
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      wr_valid <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_valid <= wr_en;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    if (k == ID_ADDR) begin : g_id
      assign regs_o[k*DATA_W +: DATA_W] = ID_VAL;
    end else if (k == STS_ADDR) begin : g_sts
      assign regs_o[k*DATA_W +: DATA_W] = '0;
    end else begin : g_rw
      assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
    end
  end
endmodule

// File: tb/tb_lb_modport_slave.sv
// Directed bench for lb_modport_slave with hand-computed expectations.
module tb_lb_modport_slave;
  localparam int ADDR_W = 12, DATA_W = 32, NUM_REGS = 16;

  logic                       clk_ir = 1'b0;
  logic                       rst_il;
  logic                       rd_en, wr_en;
  logic [ADDR_W-1:0]          addr;
  logic [DATA_W-1:0]          wr_data, sts_i;
  logic                       wr_valid, rd_valid;
  logic [DATA_W-1:0]          rd_data;
  logic [NUM_REGS*DATA_W-1:0] regs_o;

  int checks = 0;
  int errors = 0;

  lb_modport_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk_ir(clk_ir), .rst_il(rst_il), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .sts_i(sts_i), .wr_valid(wr_valid), .rd_valid(rd_valid),
    .rd_data(rd_data), .regs_o(regs_o)
  );

  always #5 clk_ir = ~clk_ir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int k);
    return regs_o[k*DATA_W +: DATA_W];
  endfunction

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_ir); #1;
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0;
  endtask

  task automatic do_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_en = 1; rd_en = 0; addr = a; wr_data = d;
    tick();
    chk($sformatf("wr_valid@%0d", a), {31'b0, wr_valid}, 32'h1);
    idle();
    tick();
    chk($sformatf("wr_valid_drop@%0d", a), {31'b0, wr_valid}, 32'h0);
  endtask

  task automatic do_rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    rd_en = 1; wr_en = 0; addr = a;
    tick();
    chk($sformatf("rd_valid@%0d", a), {31'b0, rd_valid}, 32'h1);
    chk($sformatf("rd_data@%0d", a), rd_data, exp);
    idle();
    tick();
    chk($sformatf("rd_valid_drop@%0d", a), {31'b0, rd_valid}, 32'h0);
    chk($sformatf("rd_hold@%0d", a), rd_data, exp);
  endtask

  initial begin
    rst_il = 0; rd_en = 0; wr_en = 0; addr = '0; wr_data = '0; sts_i = '0;
    // Strobes during reset must be ignored.
    wr_en = 1; rd_en = 1; addr = 12'd2; wr_data = 32'h1111_1111;
    repeat (3) tick();
    idle();
    chk("rst_wr_valid", {31'b0, wr_valid}, 32'h0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    for (int k = 2; k < NUM_REGS; k++) chk($sformatf("rst_slot%0d", k), slot(k), 32'h0);
    chk("rst_slot0", slot(0), 32'h5359_4E01);
    chk("rst_slot1", slot(1), 32'h0);
    rst_il = 1;
    tick();

    do_rd(12'd0, 32'h5359_4E01);

    do_wr(12'd2, 32'hA5A5_1234);
    chk("slot2", slot(2), 32'hA5A5_1234);
    do_rd(12'd2, 32'hA5A5_1234);

    // Dropped writes still ack, on consecutive cycles.
    wr_en = 1; addr = 12'd0; wr_data = 32'hFFFF_FFFF;
    tick();
    chk("wr_ro_valid", {31'b0, wr_valid}, 32'h1);
    addr = 12'd16;
    tick();
    chk("wr_undec_valid", {31'b0, wr_valid}, 32'h1);
    idle();
    tick();
    chk("wr_b2b_drop", {31'b0, wr_valid}, 32'h0);
    chk("slot0_ro", slot(0), 32'h5359_4E01);
    chk("slot1_ro", slot(1), 32'h0);
    do_rd(12'd0, 32'h5359_4E01);
    do_rd(12'd16, 32'hDEAD_DEAD);
    do_rd(12'hFFF, 32'hDEAD_DEAD);
    sts_i = 32'h0000_00C3;
    do_rd(12'd1, 32'h0000_00C3);

    // Read/write collision: read sees old value.
    do_wr(12'd5, 32'h1);
    rd_en = 1; wr_en = 1; addr = 12'd5; wr_data = 32'h2;
    tick();
    chk("col_rd_valid", {31'b0, rd_valid}, 32'h1);
    chk("col_wr_valid", {31'b0, wr_valid}, 32'h1);
    chk("col_rd_data", rd_data, 32'h1);
    chk("col_slot5", slot(5), 32'h2);
    idle();
    tick();
    do_rd(12'd5, 32'h2);

    // Back-to-back reads.
    do_wr(12'd3, 32'h0000_0033);
    do_wr(12'd4, 32'h0000_0044);
    do_wr(12'd15, 32'hCAFE_F00D);
    chk("slot15", slot(15), 32'hCAFE_F00D);
    rd_en = 1; addr = 12'd3;
    tick();
    chk("b2b_v3", {31'b0, rd_valid}, 32'h1);
    chk("b2b_d3", rd_data, 32'h33);
    addr = 12'd4;
    tick();
    chk("b2b_v4", {31'b0, rd_valid}, 32'h1);
    chk("b2b_d4", rd_data, 32'h44);
    addr = 12'd5;
    tick();
    chk("b2b_v5", {31'b0, rd_valid}, 32'h1);
    chk("b2b_d5", rd_data, 32'h2);
    idle();
    tick();
    chk("b2b_end", {31'b0, rd_valid}, 32'h0);
    chk("b2b_hold", rd_data, 32'h2);

    // Pending valid cancelled by asynchronous reset.
    rd_en = 1; addr = 12'd3;
    tick();
    chk("pre_rst_valid", {31'b0, rd_valid}, 32'h1);
    idle();
    rst_il = 0;
    #1;
    chk("async_rst_valid", {31'b0, rd_valid}, 32'h0);
    chk("async_rst_slot3", slot(3), 32'h0);
    chk("async_rst_slot15", slot(15), 32'h0);
    // Strobe sampled in reset gets no ack.
    rd_en = 1; wr_en = 1; addr = 12'd4; wr_data = 32'h77;
    tick();
    chk("in_rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("in_rst_wr_valid", {31'b0, wr_valid}, 32'h0);
    chk("in_rst_slot4", slot(4), 32'h0);
    idle();
    rst_il = 1;
    tick();
    chk("post_rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    do_rd(12'd2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
